// File: rtl/fwd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_pkg : shared types and constants for the forwarding unit         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fwd_pkg;

  localparam int REG_AW = 4;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE   = 2'b00;
  localparam fwd_sel_t FWD_MEM_WB = 2'b01;
  localparam fwd_sel_t FWD_EX_MEM = 2'b10;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_sel_logic.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_sel_logic : bypass select for one ALU operand                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fwd_sel_logic
  import fwd_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src_i,
  input  logic          ex_wr_i,
  input  logic [AW-1:0] ex_dst_i,
  input  logic          mem_wr_i,
  input  logic [AW-1:0] mem_dst_i,
  output fwd_sel_t      sel_o
);

  // Priority if/else: an unknown EX/MEM condition falls through to MEM/WB.
  always_comb begin
    sel_o = FWD_NONE;
    if (ex_wr_i && (ex_dst_i == src_i)) begin
      sel_o = FWD_EX_MEM;
    end else if (mem_wr_i && (mem_dst_i == src_i)) begin
      sel_o = FWD_MEM_WB;
    end else begin
      sel_o = FWD_NONE;
    end
  end

endmodule : fwd_sel_logic
`default_nettype wire

// File: rtl/forward_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | forward_unit : EX-stage operand bypass control with registered copy  |
// | Optional macro FWD_STATS_EN adds saturating forward-event counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module forward_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = fwd_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EX_MEM_regWrite,
  input  logic              MEM_WB_regWrite,
  input  logic [REG_AW-1:0] ID_EX_op1,
  input  logic [REG_AW-1:0] ID_EX_op2,
  input  logic [REG_AW-1:0] EX_MEM_op1,
  input  logic [REG_AW-1:0] EX_MEM_op2,
  input  logic [REG_AW-1:0] MEM_WB_op1,
  input  logic [REG_AW-1:0] MEM_WB_op2,
  output logic [1:0]        FowardA,
  output logic [1:0]        FowardB,
  output logic [1:0]        FowardA_q,
  output logic [1:0]        FowardB_q
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]  fwd_ex_cnt,
  output logic [CNT_W-1:0]  fwd_mem_cnt
`endif
);

  // The second destination fields are reserved and never take part in forwarding.
  logic w_unused_op2;
  assign w_unused_op2 = ^{EX_MEM_op2, MEM_WB_op2};

  fwd_sel_logic #(.AW(REG_AW)) u_sel_a (
    .src_i     (ID_EX_op1),
    .ex_wr_i   (EX_MEM_regWrite),
    .ex_dst_i  (EX_MEM_op1),
    .mem_wr_i  (MEM_WB_regWrite),
    .mem_dst_i (MEM_WB_op1),
    .sel_o     (FowardA)
  );

  fwd_sel_logic #(.AW(REG_AW)) u_sel_b (
    .src_i     (ID_EX_op2),
    .ex_wr_i   (EX_MEM_regWrite),
    .ex_dst_i  (EX_MEM_op1),
    .mem_wr_i  (MEM_WB_regWrite),
    .mem_dst_i (MEM_WB_op1),
    .sel_o     (FowardB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FowardA_q <= FWD_NONE;
      FowardB_q <= FWD_NONE;
    end else begin
      FowardA_q <= FowardA;
      FowardB_q <= FowardB;
    end
  end

`ifdef FWD_STATS_EN
  logic [1:0]       w_ex_hits;
  logic [1:0]       w_mem_hits;
  logic [CNT_W:0]   w_ex_sum;
  logic [CNT_W:0]   w_mem_sum;
  logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

  assign w_ex_hits  = {1'b0, (FowardA == FWD_EX_MEM)} + {1'b0, (FowardB == FWD_EX_MEM)};
  assign w_mem_hits = {1'b0, (FowardA == FWD_MEM_WB)} + {1'b0, (FowardB == FWD_MEM_WB)};

  // One spare carry bit detects overflow so the counters clamp at all-ones.
  always_comb begin
    w_ex_sum  = {1'b0, ex_cnt_q}  + {{(CNT_W-1){1'b0}}, w_ex_hits};
    w_mem_sum = {1'b0, mem_cnt_q} + {{(CNT_W-1){1'b0}}, w_mem_hits};
    ex_cnt_d  = w_ex_sum[CNT_W]  ? {CNT_W{1'b1}} : w_ex_sum[CNT_W-1:0];
    mem_cnt_d = w_mem_sum[CNT_W] ? {CNT_W{1'b1}} : w_mem_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      ex_cnt_q  <= ex_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign fwd_ex_cnt  = ex_cnt_q;
  assign fwd_mem_cnt = mem_cnt_q;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule : forward_unit
`default_nettype wire

// File: tb/tb_forward_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_forward_unit : randomized + directed bench for forward_unit       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_wr, mem_wr;
  logic [3:0] id1, id2, ex1, ex2, mem1, mem2;
  logic [1:0] fa, fb, fa_q, fb_q;
  logic       chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_qa = 2'b00;
  logic [1:0] exp_qb = 2'b00;

  always #5 clk = ~clk;

`ifdef FWD_STATS_EN
  logic [15:0] ex_cnt, mem_cnt;
  int          exp_ex = 0;
  int          exp_mem = 0;
`endif

  forward_unit #(.REG_AW(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .EX_MEM_regWrite (ex_wr),
    .MEM_WB_regWrite (mem_wr),
    .ID_EX_op1       (id1),
    .ID_EX_op2       (id2),
    .EX_MEM_op1      (ex1),
    .EX_MEM_op2      (ex2),
    .MEM_WB_op1      (mem1),
    .MEM_WB_op2      (mem2),
    .FowardA         (fa),
    .FowardB         (fb),
    .FowardA_q       (fa_q),
    .FowardB_q       (fb_q)
`ifdef FWD_STATS_EN
    ,
    .fwd_ex_cnt      (ex_cnt),
    .fwd_mem_cnt     (mem_cnt)
`endif
  );

  // Reference rule: newest writer wins; an unknown write/match never counts as a hit.
  function automatic logic [1:0] ref_sel(input logic ew, input logic [3:0] ed,
                                         input logic mw, input logic [3:0] md,
                                         input logic [3:0] s);
    if (ew === 1'b1 && ed === s) return 2'b10;
    if (mw === 1'b1 && md === s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

`ifdef FWD_STATS_EN
  task automatic check16(input string name, input logic [15:0] act, input int exp);
    n_checks++;
    if (act !== 16'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
`endif

  // Expected registered selects and counters track the model, not the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_qa <= 2'b00;
      exp_qb <= 2'b00;
`ifdef FWD_STATS_EN
      exp_ex  <= 0;
      exp_mem <= 0;
`endif
    end else begin
      exp_qa <= ref_sel(ex_wr, ex1, mem_wr, mem1, id1);
      exp_qb <= ref_sel(ex_wr, ex1, mem_wr, mem1, id2);
`ifdef FWD_STATS_EN
      begin
        int ne, nm;
        logic [1:0] sa, sb;
        sa = ref_sel(ex_wr, ex1, mem_wr, mem1, id1);
        sb = ref_sel(ex_wr, ex1, mem_wr, mem1, id2);
        ne = int'(sa == 2'b10) + int'(sb == 2'b10);
        nm = int'(sa == 2'b01) + int'(sb == 2'b01);
        exp_ex  <= (exp_ex + ne > 65535) ? 65535 : exp_ex + ne;
        exp_mem <= (exp_mem + nm > 65535) ? 65535 : exp_mem + nm;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check2("cmp_FowardA", fa, ref_sel(ex_wr, ex1, mem_wr, mem1, id1));
      check2("cmp_FowardB", fb, ref_sel(ex_wr, ex1, mem_wr, mem1, id2));
      check2("cmp_FowardA_q", fa_q, exp_qa);
      check2("cmp_FowardB_q", fb_q, exp_qb);
`ifdef FWD_STATS_EN
      check16("cmp_fwd_ex_cnt", ex_cnt, exp_ex);
      check16("cmp_fwd_mem_cnt", mem_cnt, exp_mem);
`endif
    end
  end

  task automatic zero_inputs();
    ex_wr = 1'b0; mem_wr = 1'b0;
    id1 = '0; id2 = '0; ex1 = '0; ex2 = '0; mem1 = '0; mem2 = '0;
  endtask

  task automatic next_slot();
    @(posedge clk);
    #2;
  endtask

  initial begin
    zero_inputs();
    #1;
    check2("reset_FowardA_q", fa_q, 2'b00);
    check2("reset_FowardB_q", fb_q, 2'b00);
    check2("reset_comb_A", fa, 2'b00);
    #11;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // EX/MEM match with MEM/WB unknown
    next_slot();
    ex_wr = 1'b1; ex1 = 4'b1001; id1 = 4'b1001; mem_wr = 1'bx; mem1 = 4'bx; id2 = 4'd3;
    #1 check2("ex_match_A", fa, 2'b10);
    @(posedge clk);
    #1 check2("ex_match_A_q", fa_q, 2'b10);

    // EX/MEM unknown falls through to MEM/WB
    #1;
    ex_wr = 1'bx; ex1 = 4'bx; mem_wr = 1'b1; mem1 = 4'b1010; id1 = 4'b1010;
    #1 check2("x_fallthru_A", fa, ref_sel(ex_wr, ex1, mem_wr, mem1, id1));

    next_slot();
    zero_inputs();
    #1;
    check2("all_zero_A", fa, 2'b00);
    check2("all_zero_B", fb, 2'b00);

    next_slot();
    ex_wr = 1'b1; ex1 = 4'b1001; id2 = 4'b1001; id1 = 4'd2;
    #1 check2("ex_match_B", fb, 2'b10);
    next_slot();
    mem_wr = 1'b1; mem1 = 4'b1010; id2 = 4'b1010; ex_wr = 1'bx; ex1 = 4'bx;
    #1 check2("x_fallthru_B", fb, ref_sel(ex_wr, ex1, mem_wr, mem1, id2));

    // Reserved second fields must not forward; register 0 forwards normally
    next_slot();
    zero_inputs();
    ex_wr = 1'b1; ex1 = 4'd7; ex2 = 4'd3; mem_wr = 1'b1; mem1 = 4'd8; mem2 = 4'd4;
    id1 = 4'd3; id2 = 4'd4;
    #1;
    check2("op2_ignored_A", fa, 2'b00);
    check2("op2_ignored_B", fb, 2'b00);
    next_slot();
    ex1 = 4'd0; id1 = 4'd0; mem1 = 4'd15; id2 = 4'd15;
    #1;
    check2("r0_forward_A", fa, 2'b10);
    check2("r15_mem_B", fb, 2'b01);

    // Both stages write R5: EX/MEM wins; async reset clears only the registered copy
    next_slot();
    ex_wr = 1'b1; ex1 = 4'd5; mem_wr = 1'b1; mem1 = 4'd5; id1 = 4'd5; id2 = 4'd5;
    #1;
    check2("both_win_A", fa, 2'b10);
    check2("both_win_B", fb, 2'b10);
    @(posedge clk);
    #1;
    check2("both_win_A_q", fa_q, 2'b10);
    check2("both_win_B_q", fb_q, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    check2("async_rst_A_q", fa_q, 2'b00);
    check2("async_rst_B_q", fb_q, 2'b00);
    check2("rst_comb_A", fa, 2'b10);
    check2("rst_comb_B", fb, 2'b10);
    @(posedge clk);
    #1 check2("rst_hold_A_q", fa_q, 2'b00);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic, addresses biased toward collisions
    for (int i = 0; i < 2000; i++) begin
      next_slot();
      ex_wr  = 1'($urandom);
      mem_wr = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        id1 = 4'($urandom_range(0, 3)); id2 = 4'($urandom_range(0, 3));
        ex1 = 4'($urandom_range(0, 3)); mem1 = 4'($urandom_range(0, 3));
      end else begin
        id1 = 4'($urandom); id2 = 4'($urandom);
        ex1 = 4'($urandom); mem1 = 4'($urandom);
      end
      ex2  = 4'($urandom);
      mem2 = 4'($urandom);
      if (i % 500 == 250) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

`ifdef FWD_STATS_EN
    next_slot();
    zero_inputs();
    ex_wr = 1'b1; ex1 = 4'd6; id1 = 4'd6; id2 = 4'd6;
    rst_n = 1'b0;
    #1;
    check16("cnt_reset_ex", ex_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check16("cnt_ex_six", ex_cnt, 6);
    check16("cnt_mem_zero", mem_cnt, 0);
    repeat (32770) @(posedge clk);
    #1;
    check16("cnt_ex_sat", ex_cnt, 65535);
    check16("cnt_mem_still_zero", mem_cnt, 0);
`endif

    next_slot();
    zero_inputs();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_forward_unit
`default_nettype wire
